sample_strobe_gen: RTL and testbench

SAMPLE_STROBE_GEN -- requirements
Module: sample_strobe_gen

---
 rtl/sample_strobe_gen_if.sv | 29 ++
 rtl/sample_strobe_gen.sv | 116 +++++++++++
 tb/tb_sample_strobe_gen.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_strobe_gen_if.sv
// Control/status bundle for sample_strobe_gen.
// The master side drives the controls and observes the strobe and status outputs.
interface sample_strobe_gen_if #(
  parameter int CNT_W  = 4,
  parameter int SCNT_W = 16
);
  logic              enable;
  logic              mode;
  logic              period_load;
  logic [CNT_W-1:0]  period_in;
  logic              strobe_ack;
  logic              clr_ovr;
  logic              strobe;
  logic              pending;
  logic              overrun;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic [SCNT_W-1:0] strobe_cnt;

  modport master (
    output enable, mode, period_load, period_in, strobe_ack, clr_ovr,
    input  strobe, pending, overrun, busy, count, strobe_cnt
  );

  modport slave (
    input  enable, mode, period_load, period_in, strobe_ack, clr_ovr,
    output strobe, pending, overrun, busy, count, strobe_cnt
  );
endinterface

// File: rtl/sample_strobe_gen.sv
// Programmable sample strobe generator: periodic or one-shot strobe every P+1 cycles,
// with acknowledge/pending handshake, sticky overrun flag and saturating strobe tally.
module sample_strobe_gen #(
  parameter int CNT_W  = 4,
  parameter int SCNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  sample_strobe_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   period_r;
  logic [CNT_W-1:0]   count_r, count_next;
  logic               mode_r, mode_next;
  logic               strobe_r, strobe_next;
  logic               start;
  logic               pending_r;
  logic               overrun_r;
  logic [SCNT_W-1:0]  strobe_cnt_r;

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_next  = state;
    count_next  = count_r;
    mode_next   = mode_r;
    strobe_next = 1'b0;
    start       = 1'b0;
    unique case (state)
      IDLE: begin
        count_next = '0;
        if (bus.enable) begin
          state_next = RUN;
          mode_next  = bus.mode;
          start      = 1'b1;
        end
      end
      RUN: begin
        // Disable wins over a coincident terminal count; >= avoids a full wrap
        // when period_r is lowered below the running count.
        if (!bus.enable) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count_r >= period_r) begin
          count_next  = '0;
          strobe_next = 1'b1;
          if (mode_r) state_next = DONE;
        end else begin
          count_next = count_r + CNT_W'(1);
        end
      end
      DONE: begin
        count_next = '0;
        if (!bus.enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count_r  <= '0;
      mode_r   <= 1'b0;
      strobe_r <= 1'b0;
    end else begin
      state    <= state_next;
      count_r  <= count_next;
      mode_r   <= mode_next;
      strobe_r <= strobe_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_r <= '1;
    end else if (bus.period_load) begin
      period_r <= bus.period_in;
    end
  end

  // A new strobe keeps pending set even when acknowledged on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (strobe_next)         pending_r <= 1'b1;
      else if (bus.strobe_ack) pending_r <= 1'b0;

      if (strobe_next && pending_r && !bus.strobe_ack) overrun_r <= 1'b1;
      else if (bus.clr_ovr)                            overrun_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_cnt_r <= '0;
    end else if (start) begin
      strobe_cnt_r <= '0;
    end else if (strobe_next && (strobe_cnt_r != '1)) begin
      strobe_cnt_r <= strobe_cnt_r + SCNT_W'(1);
    end
  end

  assign bus.strobe     = strobe_r;
  assign bus.pending    = pending_r;
  assign bus.overrun    = overrun_r;
  assign bus.busy       = (state == RUN);
  assign bus.count      = count_r;
  assign bus.strobe_cnt = strobe_cnt_r;

endmodule

// File: tb/tb_sample_strobe_gen.sv
// Scoreboard bench for sample_strobe_gen: a behavioural model predicts strobe events
// and status; a negedge monitor compares them against two DUTs (full and 2-bit tally).
module tb_sample_strobe_gen;
  localparam int CNT_W   = 4;
  localparam int SCNT_W  = 16;
  localparam int SAT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sample_strobe_gen_if #(.CNT_W(CNT_W), .SCNT_W(SCNT_W)) bus ();
  sample_strobe_gen_if #(.CNT_W(CNT_W), .SCNT_W(SAT_W))  bus_sat ();

  sample_strobe_gen #(.CNT_W(CNT_W), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  sample_strobe_gen #(.CNT_W(CNT_W), .SCNT_W(SAT_W)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_sat)
  );

  assign bus_sat.enable      = bus.enable;
  assign bus_sat.mode        = bus.mode;
  assign bus_sat.period_load = bus.period_load;
  assign bus_sat.period_in   = bus.period_in;
  assign bus_sat.strobe_ack  = bus.strobe_ack;
  assign bus_sat.clr_ovr     = bus.clr_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int tally;
    bit ovr;
  } exp_t;
  exp_t sb_q[$];

  bit m_run, m_done, m_oneshot, m_pend, m_ovr;
  int m_cnt, m_per, m_tally;

  always @(posedge clk or posedge reset) begin
    bit raise;
    raise = 1'b0;
    if (reset) begin
      m_run = 0; m_done = 0; m_oneshot = 0; m_pend = 0; m_ovr = 0;
      m_cnt = 0; m_per = CNT_MAX; m_tally = 0;
      sb_q.delete();
    end else begin
      if (m_run) begin
        if (!bus.enable) begin
          m_run = 0; m_cnt = 0;
        end else if (m_cnt >= m_per) begin
          raise = 1'b1; m_cnt = 0;
          if (m_oneshot) begin m_run = 0; m_done = 1; end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (m_done) begin
        if (!bus.enable) m_done = 0;
      end else if (bus.enable) begin
        m_run = 1; m_cnt = 0; m_tally = 0; m_oneshot = bus.mode;
      end

      if (raise) begin
        if (m_pend && !bus.strobe_ack) m_ovr = 1;
        else if (bus.clr_ovr)          m_ovr = 0;
        m_pend  = 1;
        m_tally = m_tally + 1;
        sb_q.push_back('{tally: m_tally, ovr: m_ovr});
      end else begin
        if (bus.strobe_ack) m_pend = 0;
        if (bus.clr_ovr)    m_ovr  = 0;
      end

      if (bus.period_load) m_per = int'(bus.period_in);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    check("count",          bus.count,          m_cnt);
    check("busy",           bus.busy,           m_run);
    check("pending",        bus.pending,        m_pend);
    check("overrun",        bus.overrun,        m_ovr);
    check("strobe_cnt",     bus.strobe_cnt,     sat(m_tally, SCNT_W));
    check("sat_strobe_cnt", bus_sat.strobe_cnt, sat(m_tally, SAT_W));
    if (bus.strobe) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_tally",   bus.strobe_cnt, sat(e.tally, SCNT_W));
        check("strobe_overrun", bus.overrun,    e.ovr);
      end
    end else if (sb_q.size() != 0) begin
      check("missing_strobe", 0, 1);
      sb_q.delete();
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_count(input int v, input string tag);
    int n;
    n = 0;
    while (bus.count !== CNT_W'(v) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    bus.enable = 0; bus.mode = 0; bus.period_load = 0; bus.period_in = '0;
    bus.strobe_ack = 0; bus.clr_ovr = 0;
    #1 reset = 1;
    #2;
    check("rst_strobe",     bus.strobe,     0);
    check("rst_pending",    bus.pending,    0);
    check("rst_overrun",    bus.overrun,    0);
    check("rst_busy",       bus.busy,       0);
    check("rst_count",      bus.count,      0);
    check("rst_strobe_cnt", bus.strobe_cnt, 0);
    check("rst_period_r",   dut.period_r,   CNT_MAX);
    @(negedge clk); reset = 0;
    repeat (2) @(negedge clk);
    check("no_start_without_enable", bus.busy, 0);

    // Default period 15, periodic: strobes on edges 16, 32, 48.
    bus.enable = 1; bus.mode = 0;
    repeat (49) @(negedge clk);
    check("e48_strobe",     bus.strobe,     1);
    check("e48_strobe_cnt", bus.strobe_cnt, 3);

    // Lower period to 2 so it is in force once count reaches 9.
    wait_count(8, "wait8");
    bus.period_load = 1; bus.period_in = 4'd2;
    @(negedge clk); bus.period_load = 0;
    check("count_at_9", bus.count, 9);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("count_le_9", 32'(bus.count <= 4'd9), 1);
    end
    check("overrun_sticky", bus.overrun, 1);

    // Clear overrun away from a strobe, then ack coincident with a strobe.
    wait_count(0, "wait0");
    bus.clr_ovr = 1;
    @(negedge clk); bus.clr_ovr = 0;
    check("overrun_cleared", bus.overrun, 0);
    wait_count(2, "wait2a");
    bus.strobe_ack = 1;
    @(negedge clk); bus.strobe_ack = 0;
    check("ack_coincident_strobe",  bus.strobe,  1);
    check("ack_coincident_pending", bus.pending, 1);
    check("ack_coincident_overrun", bus.overrun, 0);
    repeat (3) @(negedge clk);
    check("overrun_reset_again", bus.overrun, 1);

    // Enable falls exactly at the terminal count.
    wait_count(2, "wait2b");
    bus.enable = 0;
    @(negedge clk);
    check("stop_strobe", bus.strobe, 0);
    check("stop_busy",   bus.busy,   0);
    check("stop_count",  bus.count,  0);
    bus.strobe_ack = 1; bus.clr_ovr = 1;
    @(negedge clk); bus.strobe_ack = 0; bus.clr_ovr = 0;

    // One-shot with P=3.
    bus.period_load = 1; bus.period_in = 4'd3;
    @(negedge clk); bus.period_load = 0;
    bus.mode = 1; bus.enable = 1;
    repeat (5) @(negedge clk);
    check("oneshot_strobe",     bus.strobe,     1);
    check("oneshot_strobe_cnt", bus.strobe_cnt, 1);
    check("oneshot_busy",       bus.busy,       0);
    repeat (6) @(negedge clk);
    check("done_count", bus.count,      0);
    check("done_hold",  bus.strobe_cnt, 1);
    bus.enable = 0;
    @(negedge clk); bus.enable = 1;
    @(negedge clk);
    check("restart_busy",       bus.busy,       1);
    check("restart_strobe_cnt", bus.strobe_cnt, 0);

    // P=0 periodic: continuous strobe; 2-bit tally saturates.
    bus.enable = 0; bus.mode = 0; bus.period_load = 1; bus.period_in = '0;
    @(negedge clk); bus.period_load = 0; bus.enable = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("p0_strobe", bus.strobe, 1);
    end
    check("p0_strobe_cnt",  bus.strobe_cnt,     6);
    check("p0_sat_tally",   bus_sat.strobe_cnt, 3);

    // Randomised traffic.
    bus.enable = 0;
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      bus.enable      = ($urandom_range(0, 19) != 0);
      bus.mode        = 1'($urandom_range(0, 1));
      bus.period_load = ($urandom_range(0, 15) == 0);
      bus.period_in   = CNT_W'($urandom_range(0, 7));
      bus.strobe_ack  = ($urandom_range(0, 2) == 0);
      bus.clr_ovr     = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    bus.period_load = 0; bus.strobe_ack = 0; bus.clr_ovr = 0;

    // Asynchronous reset between edges while running.
    bus.enable = 0;
    @(negedge clk);
    bus.mode = 0; bus.period_load = 1; bus.period_in = 4'd5;
    @(negedge clk); bus.period_load = 0; bus.enable = 1;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("async_strobe",     bus.strobe,     0);
    check("async_pending",    bus.pending,    0);
    check("async_overrun",    bus.overrun,    0);
    check("async_busy",       bus.busy,       0);
    check("async_count",      bus.count,      0);
    check("async_strobe_cnt", bus.strobe_cnt, 0);
    check("async_period_r",   dut.period_r,   CNT_MAX);
    @(negedge clk); reset = 0; bus.enable = 0;
    repeat (3) @(negedge clk);
    check("queue_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
